hub75_scan_driver: RTL and testbench

//  Scans the 64x32 HUB75 LED panel (1/16 scan, upper/lower halves) for the game display.

---
 rtl/hub75_scan_driver_pkg.sv | 17 +
 rtl/hub75_timer.sv | 29 ++
 rtl/hub75_scan_driver.sv | 152 +++++++++++++++
 tb/tb_hub75_scan_driver.sv | 325 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hub75_scan_driver_pkg.sv
// Shared definitions for the HUB75 scan driver and the pixel/matrix generator.
// Panel geometry: 64 columns, 1/16 scan, with upper and lower halves shifted together.
// Scan FSM state encoding: IDLE, SHIFT, BLANK, LATCH, DISPLAY.
package hub75_scan_driver_pkg;

  localparam int PANEL_COLS      = 64;
  localparam int PANEL_ROWS_HALF = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SHIFT   = 3'd1,
    ST_BLANK   = 3'd2,
    ST_LATCH   = 3'd3,
    ST_DISPLAY = 3'd4
  } state_t;

endpackage

// File: rtl/hub75_timer.sv
// Purpose: loadable down-counter; done is high while the count is zero.
// Latency: a load of N gives N+1 cycles in the loaded phase before done.
// Backpressure: none; load takes priority over counting.
// Ports: clk, rst (async active-low), load/load_val (start a count), done.
module hub75_timer #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/hub75_scan_driver.sv
// Purpose: scans a 64x32 HUB75 panel (1/16 scan) by addressing the pixel generator and serialising its bits.
// Latency: panel data is registered one cycle after the col/row address is presented; row period 2*COLS+BLANK_CYC+1+ON_CYC.
// Backpressure: none; en=0 parks the scan (panel dark, row held) on the next cycle.
// Ports: clk, rst (async active-low), en; col/row to the generator; R0..B1 from it;
//        p_r0..p_b1, p_clk, p_lat, p_oe_n, p_a to the panel; frame_done pulse.
module hub75_scan_driver
  import hub75_scan_driver_pkg::*;
#(
  parameter int COLS      = PANEL_COLS,
  parameter int ROWS      = PANEL_ROWS_HALF,
  parameter int BLANK_CYC = 2,
  parameter int ON_CYC    = 256
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    en,
  output logic [$clog2(COLS)-1:0] col,
  output logic [$clog2(ROWS)-1:0] row,
  input  logic                    R0,
  input  logic                    G0,
  input  logic                    B0,
  input  logic                    R1,
  input  logic                    G1,
  input  logic                    B1,
  output logic                    p_r0,
  output logic                    p_g0,
  output logic                    p_b0,
  output logic                    p_r1,
  output logic                    p_g1,
  output logic                    p_b1,
  output logic                    p_clk,
  output logic                    p_lat,
  output logic                    p_oe_n,
  output logic [$clog2(ROWS)-1:0] p_a,
  output logic                    frame_done
);

  localparam int CW = $clog2(COLS);
  localparam int RW = $clog2(ROWS);
  localparam int TW = $clog2(((ON_CYC > BLANK_CYC) ? ON_CYC : BLANK_CYC) + 1);

  localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
  // Timer is loaded with N-1 so the phase lasts N cycles including the done cycle.
  localparam logic [TW-1:0] BLANK_LD = TW'(BLANK_CYC - 1);
  localparam logic [TW-1:0] ON_LD    = TW'(ON_CYC - 1);

  state_t        state, state_nxt;
  logic          phase, phase_nxt;
  logic          t_load;
  logic [TW-1:0] t_val;
  logic          t_done;
  logic          row_end;

  hub75_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (t_load),
    .load_val (t_val),
    .done     (t_done)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= ST_IDLE;
      phase <= 1'b0;
    end else begin
      state <= state_nxt;
      phase <= phase_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    phase_nxt = 1'b0;
    t_load    = 1'b0;
    t_val     = BLANK_LD;
    case (state)
      ST_IDLE: begin
        if (en) state_nxt = ST_SHIFT;
      end
      ST_SHIFT: begin
        phase_nxt = ~phase;
        if (phase && (col == COL_LAST)) begin
          state_nxt = ST_BLANK;
          t_load    = 1'b1;
          t_val     = BLANK_LD;
        end
      end
      ST_BLANK: begin
        if (t_done) state_nxt = ST_LATCH;
      end
      ST_LATCH: begin
        state_nxt = ST_DISPLAY;
        t_load    = 1'b1;
        t_val     = ON_LD;
      end
      ST_DISPLAY: begin
        if (t_done) state_nxt = ST_SHIFT;
      end
      default: state_nxt = ST_IDLE;
    endcase
    // Dropping en parks the scan from any state on the next cycle.
    if (!en) begin
      state_nxt = ST_IDLE;
      phase_nxt = 1'b0;
      t_load    = 1'b0;
    end
  end

  // A row only counts as shown if its display phase ran to completion while enabled.
  assign row_end = (state == ST_DISPLAY) && t_done && en;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      col        <= '0;
      row        <= '0;
      p_a        <= '0;
      {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} <= '0;
      p_clk      <= 1'b0;
      p_lat      <= 1'b0;
      p_oe_n     <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      if ((state == ST_SHIFT) && (state_nxt == ST_SHIFT) && phase) begin
        col <= col + 1'b1;
      end else if (state_nxt != ST_SHIFT) begin
        col <= '0;
      end

      if (row_end) begin
        row <= (row == ROW_LAST) ? '0 : row + 1'b1;
      end
      frame_done <= row_end && (row == ROW_LAST);

      if (state_nxt == ST_LATCH) begin
        p_a <= row;
      end

      // Generator output is valid for the address presented during phase 0.
      if ((state == ST_SHIFT) && !phase && en) begin
        {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1} <= {R0, G0, B0, R1, G1, B1};
      end

      // Strobes are registered from the next state so they line up with it exactly.
      p_clk  <= (state_nxt == ST_SHIFT) && phase_nxt;
      p_lat  <= (state_nxt == ST_LATCH);
      p_oe_n <= (state_nxt != ST_DISPLAY);
    end
  end

endmodule

// File: tb/tb_hub75_scan_driver.sv
// Purpose: directed self-checking bench for hub75_scan_driver (default build plus ON_CYC=1/BLANK_CYC=1 build).
// Latency: outputs sampled on the falling clock edge; cycle 0 is the first SHIFT cycle after en rises.
// Backpressure: n/a; every wait on the design is bounded.
module tb_hub75_scan_driver;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b0;
  logic       en2 = 1'b0;

  logic [5:0] col, col2;
  logic [3:0] row, row2, p_a, p_a2;
  logic       R0, G0, B0, R1, G1, B1;
  logic       R0_2, G0_2, B0_2, R1_2, G1_2, B1_2;
  logic       p_r0, p_g0, p_b0, p_r1, p_g1, p_b1;
  logic       q_r0, q_g0, q_b0, q_r1, q_g1, q_b1;
  logic       p_clk, p_lat, p_oe_n, frame_done;
  logic       p_clk2, p_lat2, p_oe_n2, frame_done2;
  logic [5:0] pdat, pdat2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  // Generator model: R0=col[0], B1=row[0], remaining bits from other address bits.
  assign R0 = col[0];  assign G0 = col[1];  assign B0 = col[2];
  assign R1 = row[1];  assign G1 = row[2];  assign B1 = row[0];
  assign R0_2 = col2[0]; assign G0_2 = col2[1]; assign B0_2 = col2[2];
  assign R1_2 = row2[1]; assign G1_2 = row2[2]; assign B1_2 = row2[0];
  assign pdat  = {p_r0, p_g0, p_b0, p_r1, p_g1, p_b1};
  assign pdat2 = {q_r0, q_g0, q_b0, q_r1, q_g1, q_b1};

  hub75_scan_driver dut (
    .clk(clk), .rst(rst), .en(en), .col(col), .row(row),
    .R0(R0), .G0(G0), .B0(B0), .R1(R1), .G1(G1), .B1(B1),
    .p_r0(p_r0), .p_g0(p_g0), .p_b0(p_b0), .p_r1(p_r1), .p_g1(p_g1), .p_b1(p_b1),
    .p_clk(p_clk), .p_lat(p_lat), .p_oe_n(p_oe_n), .p_a(p_a), .frame_done(frame_done)
  );

  hub75_scan_driver #(.BLANK_CYC(1), .ON_CYC(1)) dut2 (
    .clk(clk), .rst(rst), .en(en2), .col(col2), .row(row2),
    .R0(R0_2), .G0(G0_2), .B0(B0_2), .R1(R1_2), .G1(G1_2), .B1(B1_2),
    .p_r0(q_r0), .p_g0(q_g0), .p_b0(q_b0), .p_r1(q_r1), .p_g1(q_g1), .p_b1(q_b1),
    .p_clk(p_clk2), .p_lat(p_lat2), .p_oe_n(p_oe_n2), .p_a(p_a2), .frame_done(frame_done2)
  );

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; en2 = 1'b0;
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({col, row, p_a} !== 14'd0) begin
      errors++; $display("FAIL reset_addr col=%0d row=%0d p_a=%0d expected all 0", col, row, p_a);
    end
    checks++;
    if (pdat !== 6'd0) begin
      errors++; $display("FAIL reset_data data=%b expected 000000", pdat);
    end
    checks++;
    if ({p_clk, p_lat, p_oe_n, frame_done} !== 4'b0010) begin
      errors++; $display("FAIL reset_strobes clk/lat/oe_n/fd=%b expected 0010", {p_clk, p_lat, p_oe_n, frame_done});
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({p_clk, p_lat, p_oe_n, col} !== {3'b001, 6'd0}) begin
      errors++; $display("FAIL idle_parked clk/lat/oe_n=%b col=%0d expected 001 col=0", {p_clk, p_lat, p_oe_n}, col);
    end
  endtask

  task automatic test_shift_row0();
    int rises;
    logic prev_clk;
    logic [5:0] c;
    logic [5:0] exp_dat;
    rises = 0;
    prev_clk = 1'b0;
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 128; k++) begin
      c = 6'(k >> 1);
      checks++;
      if (p_clk !== k[0] || col !== c || p_oe_n !== 1'b1) begin
        errors++; $display("FAIL shift_timing k=%0d p_clk=%b col=%0d oe_n=%b expected p_clk=%b col=%0d oe_n=1",
                           k, p_clk, col, p_oe_n, k[0], c);
      end
      if (p_clk && !prev_clk) rises++;
      prev_clk = p_clk;
      if (k[0]) begin
        exp_dat = {c[0], c[1], c[2], 3'b000};
        checks++;
        if (pdat !== exp_dat) begin
          errors++; $display("FAIL shift_data col=%0d data=%b expected %b", c, pdat, exp_dat);
        end
      end else if (k >= 2) begin
        c = c - 6'd1;
        exp_dat = {c[0], c[1], c[2], 3'b000};
        checks++;
        if (pdat !== exp_dat) begin
          errors++; $display("FAIL shift_hold k=%0d data=%b expected %b", k, pdat, exp_dat);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (rises !== 64) begin
      errors++; $display("FAIL shift_edges rises=%0d expected 64", rises);
    end
  endtask

  task automatic test_blank_latch_display();
    int low;
    int n;
    for (int k = 0; k < 2; k++) begin
      checks++;
      if ({p_oe_n, p_lat, p_clk} !== 3'b100) begin
        errors++; $display("FAIL blank k=%0d oe_n/lat/clk=%b expected 100", k, {p_oe_n, p_lat, p_clk});
      end
      @(negedge clk);
    end
    checks++;
    if (p_lat !== 1'b1 || p_a !== 4'd0 || p_oe_n !== 1'b1) begin
      errors++; $display("FAIL latch lat=%b p_a=%0d oe_n=%b expected lat=1 p_a=0 oe_n=1", p_lat, p_a, p_oe_n);
    end
    @(negedge clk);
    checks++;
    if (p_lat !== 1'b0) begin
      errors++; $display("FAIL latch_width lat=%b expected 0", p_lat);
    end
    low = 0;
    n = 0;
    while (p_oe_n === 1'b0 && n < 400) begin
      low++;
      n++;
      @(negedge clk);
    end
    checks++;
    if (low !== 256) begin
      errors++; $display("FAIL display_len low_cycles=%0d expected 256", low);
    end
    checks++;
    if (row !== 4'd1 || col !== 6'd0 || p_clk !== 1'b0) begin
      errors++; $display("FAIL next_row row=%0d col=%0d p_clk=%b expected row=1 col=0 p_clk=0", row, col, p_clk);
    end
  endtask

  task automatic test_frame();
    int fd_cnt;
    int fd_at;
    int lat_n;
    fd_cnt = 0;
    fd_at = -1;
    lat_n = 0;
    en = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    en = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 6200; k++) begin
      if (frame_done === 1'b1) begin
        if (fd_cnt == 0) fd_at = k;
        fd_cnt++;
      end
      if (p_lat === 1'b1) begin
        checks++;
        if (p_a !== 4'(lat_n)) begin
          errors++; $display("FAIL pa_order latch#%0d p_a=%0d expected %0d", lat_n, p_a, lat_n);
        end
        lat_n++;
      end
      if (k == 6191) begin
        checks++;
        if (row !== 4'd15) begin
          errors++; $display("FAIL last_row row=%0d expected 15", row);
        end
      end
      if (k == 6192) begin
        checks++;
        if (row !== 4'd0 || col !== 6'd0) begin
          errors++; $display("FAIL frame_wrap row=%0d col=%0d expected 0 0", row, col);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (fd_at !== 6192) begin
      errors++; $display("FAIL frame_done_cycle got=%0d expected 6192", fd_at);
    end
    checks++;
    if (fd_cnt !== 1) begin
      errors++; $display("FAIL frame_done_pulses got=%0d expected 1", fd_cnt);
    end
    checks++;
    if (lat_n !== 16) begin
      errors++; $display("FAIL latch_count got=%0d expected 16", lat_n);
    end
  endtask

  task automatic test_en_drop();
    int n;
    n = 0;
    while (!(row === 4'd5 && col === 6'd30 && p_clk === 1'b0) && n < 4000) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 4000) begin
      errors++; $display("FAIL en_drop_reach row=%0d col=%0d expected row 5 col 30 within bound", row, col);
    end
    en = 1'b0;
    @(negedge clk);
    checks++;
    if ({p_oe_n, p_clk, p_lat} !== 3'b100 || col !== 6'd0 || row !== 4'd5 || p_a !== 4'd4) begin
      errors++; $display("FAIL en_drop_idle oe_n/clk/lat=%b col=%0d row=%0d p_a=%0d expected 100 0 5 4",
                         {p_oe_n, p_clk, p_lat}, col, row, p_a);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (p_oe_n !== 1'b1 || col !== 6'd0 || row !== 4'd5 || frame_done !== 1'b0) begin
      errors++; $display("FAIL en_drop_hold oe_n=%b col=%0d row=%0d fd=%b expected 1 0 5 0", p_oe_n, col, row, frame_done);
    end
    en = 1'b1;
    @(negedge clk);
    checks++;
    if (col !== 6'd0 || row !== 4'd5 || p_clk !== 1'b0) begin
      errors++; $display("FAIL restart col=%0d row=%0d p_clk=%b expected 0 5 0", col, row, p_clk);
    end
    @(negedge clk);
    checks++;
    if (p_clk !== 1'b1 || pdat !== 6'b000011) begin
      errors++; $display("FAIL restart_data p_clk=%b data=%b expected 1 000011", p_clk, pdat);
    end
    n = 0;
    while (p_lat !== 1'b1 && n < 300) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 300 || p_a !== 4'd5) begin
      errors++; $display("FAIL restart_latch p_a=%0d wait=%0d expected p_a=5 within bound", p_a, n);
    end
  endtask

  task automatic test_reset_mid_display();
    int n;
    n = 0;
    while (p_oe_n !== 1'b0 && n < 50) begin
      n++;
      @(negedge clk);
    end
    checks++;
    if (n >= 50) begin
      errors++; $display("FAIL mid_display_reach oe_n=%b expected 0 within bound", p_oe_n);
    end
    repeat (10) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({p_oe_n, p_clk, p_lat} !== 3'b100 || col !== 6'd0 || row !== 4'd0 || p_a !== 4'd0) begin
      errors++; $display("FAIL async_reset oe_n/clk/lat=%b col=%0d row=%0d p_a=%0d expected 100 0 0 0",
                         {p_oe_n, p_clk, p_lat}, col, row, p_a);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_short_build();
    int lat1, lat2, oe1, oe2, oe_low, fd_seen;
    lat1 = -1; lat2 = -1; oe1 = -1; oe2 = -1; oe_low = 0; fd_seen = 0;
    en2 = 1'b1;
    @(negedge clk);
    for (int k = 0; k <= 261; k++) begin
      if (p_lat2 === 1'b1) begin
        if (lat1 < 0) lat1 = k; else if (lat2 < 0) lat2 = k;
        checks++;
        if (p_a2 !== ((lat2 < 0) ? 4'd0 : 4'd1) || col2 !== 6'd0) begin
          errors++; $display("FAIL short_latch k=%0d p_a=%0d col=%0d", k, p_a2, col2);
        end
      end
      if (p_oe_n2 === 1'b0) begin
        oe_low++;
        if (oe1 < 0) oe1 = k; else if (oe2 < 0) oe2 = k;
      end
      if (frame_done2 === 1'b1) fd_seen++;
      if (k == 3) begin
        checks++;
        if (p_clk2 !== 1'b1 || pdat2 !== 6'b100000) begin
          errors++; $display("FAIL short_shift p_clk=%b data=%b expected 1 100000", p_clk2, pdat2);
        end
      end
      @(negedge clk);
    end
    checks++;
    if (lat1 !== 129 || (lat2 - lat1) !== 131) begin
      errors++; $display("FAIL short_period lat1=%0d lat2=%0d expected 129 260", lat1, lat2);
    end
    checks++;
    if (oe_low !== 2 || oe1 !== 130 || oe2 !== 261) begin
      errors++; $display("FAIL short_oe low=%0d at %0d,%0d expected 2 at 130,261", oe_low, oe1, oe2);
    end
    checks++;
    if (row2 !== 4'd2 || fd_seen !== 0) begin
      errors++; $display("FAIL short_rows row=%0d fd=%0d expected 2 0", row2, fd_seen);
    end
    en2 = 1'b0;
  endtask

  initial begin
    test_reset();
    test_shift_row0();
    test_blank_latch_display();
    test_frame();
    test_en_drop();
    test_reset_mid_display();
    test_short_build();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
